uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart` byte transmitter among NUM_REQ requesters. Each requester sends a packet: a stream of bytes, with the final byte tagged by `req_last`. The grant stays locked to one requester until its packet ends or a byte-gap watchdog fires. The block sits between the firmware-side message sources (status, telemetry, debug echo) and the `uart` ports `data_in`, `send_in` and `tx_ready_out`.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- TIMEOUT, 65535: clk_in cycles the owner may leave idle between bytes before the grant is revoked; legal range 2..2^TMR_W-1.
- TMR_W, 16: watchdog counter width.
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  requester i presents a byte.
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- req_last  in  NUM_REQ  presented byte is the final byte of the packet.
- req_ready  out  NUM_REQ  combinational accept; a byte transfers on a cycle where valid[i] & ready[i].
- grant_out  out  NUM_REQ  one-hot packet owner, registered; 0 when no owner.
- uart_data_out  out  8  byte to `uart` data_in, registered.
- uart_send_out  out  1  one-cycle send strobe to `uart` send_in, registered.
- uart_tx_ready_in  in  1  `uart` tx_ready_out.
- busy_out  out  1  state != IDLE, registered.
- timeout_out  out  1  one-cycle pulse when the watchdog revokes a grant.

## Operation
- States: IDLE, GUARD, WAIT_TX, HOLD. Reset values: state=IDLE, grant_out=0, uart_data_out=0, uart_send_out=0, busy_out=0, timeout_out=0, timer=0, last_ptr=NUM_REQ-1 (requester 0 has first priority).
- Winner in IDLE: the first i with req_valid[i], searching (last_ptr+1) mod NUM_REQ upward with wrap.
- req_ready[i] = uart_tx_ready_in & ((IDLE & winner==i & any valid) | (HOLD & grant_out[i])). All other bits are 0, including every cycle in GUARD and WAIT_TX.
- Accept edge, from IDLE or HOLD:
  - uart_data_out <= req_data[i]; uart_send_out <= 1 for exactly one cycle.
  - last_flag <= req_last[i]; grant_out <= one-hot(i); timer <= 0; state <= GUARD.
- GUARD: lasts one cycle and ignores uart_tx_ready_in, which is still high on the send cycle. Next state is WAIT_TX.
- WAIT_TX: waits for uart_tx_ready_in=1, i.e. the stop bit has completed.
  - If last_flag=1: release. grant_out <= 0; last_ptr <= owner; state <= IDLE.
  - If last_flag=0: state <= HOLD; timer <= 0.
- HOLD: only the owner can be accepted. Other requesters are ignored even if valid.
  - If the owner is not accepted: timer <= timer+1.
  - When timer == TIMEOUT-1 with no accept: timeout_out <= 1 for one cycle, release exactly as above, state <= IDLE. The truncated packet is not resumed.
- A single-byte packet (req_last=1 on the first byte) runs IDLE -> GUARD -> WAIT_TX -> IDLE.
- Requester valid dropping mid-packet is legal; it only runs the watchdog.
- Reset mid-packet: all outputs return to reset values immediately. A byte already inside `uart` completes or aborts according to the uart's own reset.

## Timing
- Accept at edge t: uart_send_out=1 and uart_data_out valid during cycle t+1, GUARD during t+1, WAIT_TX from t+2.
- `uart` drops tx_ready one cycle after send_in, so WAIT_TX first samples it low. No second send can occur while the uart is busy.
- Release to the next grant: the release edge moves to IDLE, and the new winner can be accepted in the following cycle. The minimum gap between packets is one idle cycle.
- Byte-to-byte latency within a packet: after tx_ready rises, the first cycle is in HOLD and the next byte is accepted on that cycle's edge.
- The watchdog counts HOLD cycles only. Any cycle in which uart_tx_ready_in=0 during HOLD does not advance the timer.

## Test plan
- Single requester, NUM_REQ=4: req 2 sends 0x55, 0xA3(last). Required: the txd line carries both frames, grant_out=4'b0100 throughout, grant_out=0 after, then last_ptr=2.
- Contention: reqs 0, 1 and 3 all hold valid 2-byte packets from reset. Required grant order 0, 1, 3, 0. No interleaving of bytes between packets.
- Lock: req 1 owns a 3-byte packet while req 0 asserts valid. Required: req_ready[0]=0 until req 1's last byte completes, then req 0 is granted.
- Watchdog with TIMEOUT=20: req 3 sends a byte with last=0, then drops valid. Required: timeout_out pulses exactly 20 HOLD cycles after entering HOLD; grant_out=0; the next request is granted normally.
- Send spacing: a back-to-back stream of 8 bytes. Required: uart_send_out is never high while uart_tx_ready_in=0, and there are exactly 8 strobes.
- Reset mid-packet: assert rst_in during WAIT_TX. Required: every output is 0 asynchronously, and after release requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the uart transmit arbiter: one valid/data/last lane
// per requester and the matching per-lane ready.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  // Message sources drive bytes and observe ready.
  modport master (output req_valid, output req_data, output req_last, input req_ready);
  // The arbiter observes bytes and drives ready.
  modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart byte transmitter.
// The grant stays locked to one requester until its last byte has left the
// uart or the byte-gap watchdog revokes it.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65535,
  parameter int TMR_W   = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  uart_tx_arbiter_if.slave    req_if,
  output logic [NUM_REQ-1:0]  grant_out,
  output logic [7:0]          uart_data_out,
  output logic                uart_send_out,
  input  logic                uart_tx_ready_in,
  output logic                busy_out,
  output logic                timeout_out
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GUARD   = 2'd1,
    WAIT_TX = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         data_q, data_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               last_flag_q, last_flag_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;

  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   sel;
  logic               win_found;
  logic               accept;

  // Round-robin search: first valid requester after the previous owner, with wrap.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can hold
    // an old value, which is what would otherwise infer a latch.
    winner    = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_ptr_q) + k) % NUM_REQ);
      if (!win_found && req_if.req_valid[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  // Combinational ready: the IDLE winner, or the locked owner while in HOLD.
  always_comb begin
    sel              = (state_q == IDLE) ? winner : owner_q;
    accept           = 1'b0;
    req_if.req_ready = '0;
    if (uart_tx_ready_in) begin
      if (state_q == IDLE && win_found) begin
        accept                   = 1'b1;
        req_if.req_ready[winner] = 1'b1;
      end else if (state_q == HOLD) begin
        accept           = req_if.req_valid[owner_q];
        req_if.req_ready = grant_q;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    data_d      = data_q;
    send_d      = 1'b0;
    timeout_d   = 1'b0;
    last_flag_d = last_flag_q;
    timer_d     = timer_q;
    last_ptr_d  = last_ptr_q;
    owner_d     = owner_q;

    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          data_d      = req_if.req_data[{sel, 3'b000} +: 8];
          send_d      = 1'b1;
          last_flag_d = req_if.req_last[sel];
          grant_d     = NUM_REQ'(1) << sel;
          owner_d     = sel;
          timer_d     = '0;
          state_d     = GUARD;
        end else if (state_q == HOLD && uart_tx_ready_in) begin
          // Idle owner: advance the watchdog, revoke the grant when it expires.
          if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            timeout_d  = 1'b1;
            grant_d    = '0;
            last_ptr_d = owner_q;
            state_d    = IDLE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      // The uart still shows ready on the send cycle, so skip one cycle.
      GUARD: state_d = WAIT_TX;
      WAIT_TX: begin
        if (uart_tx_ready_in) begin
          if (last_flag_q) begin
            grant_d    = '0;
            last_ptr_d = owner_q;
            state_d    = IDLE;
          end else begin
            timer_d = '0;
            state_d = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_in) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      data_q      <= '0;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      last_flag_q <= 1'b0;
      timer_q     <= '0;
      last_ptr_q  <= PTR_W'(NUM_REQ - 1);
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      last_flag_q <= last_flag_d;
      timer_q     <= timer_d;
      last_ptr_q  <= last_ptr_d;
      owner_q     <= owner_d;
    end
  end

  assign grant_out     = grant_q;
  assign uart_data_out = data_q;
  assign uart_send_out = send_q;
  assign busy_out      = busy_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers and a uart model
// on the falling edge, a packet-level round-robin reference model filling an
// expected-byte queue, and a monitor that checks every send strobe.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 20;
  localparam int TMR_W   = 16;

  typedef logic [8:0] ent_t;  // {last, data}

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic [NUM_REQ-1:0] grant_out;
  logic [7:0]         uart_data_out;
  logic               uart_send_out;
  logic               uart_tx_ready_in = 1'b1;
  logic               busy_out;
  logic               timeout_out;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) req_if ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT),
    .TMR_W  (TMR_W)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .req_if          (req_if),
    .grant_out       (grant_out),
    .uart_data_out   (uart_data_out),
    .uart_send_out   (uart_send_out),
    .uart_tx_ready_in(uart_tx_ready_in),
    .busy_out        (busy_out),
    .timeout_out     (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  // Stimulus byte queues, reference-model packet queues, expected sends.
  ent_t               rq      [NUM_REQ][$];
  logic [7:0]         mp_data [NUM_REQ][$];
  int                 mp_len  [NUM_REQ][$];
  logic [10:0]        exp_q   [$];          // {requester, byte}
  int                 model_ptr   = NUM_REQ - 1;
  int                 n_checks    = 0;
  int                 n_pass      = 0;
  int                 cyc         = 0;
  int                 rise_edge   = 0;
  int                 busy_cnt    = 0;
  int                 sends       = 0;
  bit                 send_pend   = 1'b0;
  bit                 exp_timeout = 1'b0;
  logic [NUM_REQ-1:0] acc         = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic push_raw(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic add_packet(input int r, input int len, input logic [63:0] bytes);
    logic [7:0] d;
    for (int b = 0; b < len; b++) begin
      d = bytes[8*b +: 8];
      push_raw(r, d, (b == len - 1));
      mp_data[r].push_back(d);
    end
    mp_len[r].push_back(len);
  endtask

  // Reference model: whole packets are granted in round-robin order among
  // requesters with pending packets, starting after the previous owner.
  task automatic model_schedule();
    bit found;
    do begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ && !found; k++) begin
        int r = (model_ptr + k) % NUM_REQ;
        if (mp_len[r].size() > 0) begin
          int n = mp_len[r].pop_front();
          for (int b = 0; b < n; b++) begin
            logic [7:0] d = mp_data[r].pop_front();
            exp_q.push_back({3'(r), d});
          end
          model_ptr = r;
          found     = 1'b1;
        end
      end
    end while (found);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      mp_data[i].delete();
      mp_len[i].delete();
    end
    exp_q.delete();
  endtask

  task automatic wait_done(input string name);
    int t;
    int pend;
    t = 0;
    while ((exp_q.size() != 0 || busy_out !== 1'b0 || exp_timeout) && t < 5000) begin
      @(negedge clk_in);
      t++;
    end
    check({name, "_drain"}, 32'(t < 5000), 32'd1);
    pend = 0;
    for (int i = 0; i < NUM_REQ; i++) pend += rq[i].size();
    check({name, "_all_accepted"}, 32'(pend), 32'd0);
    check({name, "_grant_released"}, 32'(grant_out), 32'd0);
  endtask

  // Requester drivers and uart model, all on the falling edge.
  initial begin : bfm
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   l;
    logic [8*NUM_REQ-1:0] d;
    ent_t                 h;
    req_if.req_valid = '0;
    req_if.req_data  = '0;
    req_if.req_last  = '0;
    forever begin
      @(negedge clk_in);
      // uart: tx_ready drops one cycle after the send strobe, then a frame time.
      if (send_pend) begin
        uart_tx_ready_in = 1'b0;
        busy_cnt         = $urandom_range(3, 12);
        send_pend        = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          uart_tx_ready_in = 1'b1;
          rise_edge        = cyc + 1;
        end
      end
      if (uart_send_out) begin
        check("send_spacing", {30'd0, uart_tx_ready_in, (busy_cnt == 0)}, 32'd3);
        send_pend = 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (acc[i] && rq[i].size() > 0) h = rq[i].pop_front();
      acc = '0;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0) begin
          h            = rq[i][0];
          v[i]         = 1'b1;
          l[i]         = h[8];
          d[8*i +: 8]  = h[7:0];
        end
      end
      req_if.req_valid = v;
      req_if.req_last  = l;
      req_if.req_data  = d;
      #4;
      acc = rst_in ? '0 : (req_if.req_valid & req_if.req_ready);
      if (!rst_in && grant_out != '0 && (req_if.req_valid & ~grant_out) != '0)
        check("lock_ready", 32'(req_if.req_ready & ~grant_out), 32'd0);
    end
  end

  // Monitor: each send strobe must match the head of the expected queue.
  initial begin : monitor
    logic [10:0]        e;
    logic [NUM_REQ-1:0] eg;
    forever begin
      @(posedge clk_in);
      cyc++;
      #1;
      if (uart_send_out) begin
        sends++;
        check("send_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          eg = NUM_REQ'(1) << e[10:8];
          check("send_byte", 32'({busy_out, grant_out, uart_data_out}), 32'({1'b1, eg, e[7:0]}));
        end
      end
      if (timeout_out) begin
        check("timeout_expected", 32'(exp_timeout), 32'd1);
        check("timeout_edge", 32'(cyc), 32'(rise_edge + TIMEOUT));
        check("timeout_grant", 32'({busy_out, grant_out}), 32'd0);
        exp_timeout = 1'b0;
      end
    end
  end

  initial begin : main
    int np;
    int t;
    #2 rst_in = 1'b1;
    #1;
    check("reset_outputs", 32'({grant_out, uart_data_out, uart_send_out, busy_out, timeout_out}), 32'd0);
    check("reset_ready", 32'(req_if.req_ready), 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // Single requester, two-byte packet.
    add_packet(2, 2, 64'hA355);
    model_schedule();
    wait_done("single");

    // Next arbitration resumes after requester 2.
    add_packet(0, 2, {$urandom, $urandom});
    add_packet(1, 2, {$urandom, $urandom});
    add_packet(3, 2, {$urandom, $urandom});
    model_schedule();
    wait_done("rr_after_2");

    // Contention from reset: order 0, 1, 3, 0.
    @(negedge clk_in);
    rst_in = 1'b1;
    clear_queues();
    model_ptr = NUM_REQ - 1;
    repeat (2) @(negedge clk_in);
    add_packet(0, 2, {$urandom, $urandom});
    add_packet(1, 2, {$urandom, $urandom});
    add_packet(3, 2, {$urandom, $urandom});
    add_packet(0, 2, {$urandom, $urandom});
    model_schedule();
    rst_in = 1'b0;
    wait_done("contention");

    // Lock: requester 1 keeps the grant for all three bytes.
    add_packet(1, 3, {$urandom, $urandom});
    add_packet(0, 2, {$urandom, $urandom});
    model_schedule();
    wait_done("lock");

    // Watchdog: requester 3 sends one non-final byte and goes quiet.
    push_raw(3, 8'h3C, 1'b0);
    exp_q.push_back({3'd3, 8'h3C});
    exp_timeout = 1'b1;
    model_ptr   = 3;
    wait_done("watchdog");
    add_packet(3, 1, {$urandom, $urandom});
    add_packet(0, 1, {$urandom, $urandom});
    model_schedule();
    wait_done("after_timeout");

    // Back-to-back stream of eight bytes.
    sends = 0;
    add_packet(1, 8, {$urandom, $urandom});
    model_schedule();
    wait_done("stream8");
    check("stream8_strobes", 32'(sends), 32'd8);

    // Random packet mixes.
    for (int round = 0; round < 10; round++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) add_packet(r, $urandom_range(1, 6), {$urandom, $urandom});
      end
      model_schedule();
      wait_done("random");
    end

    // Reset while the first byte of a packet is in WAIT_TX.
    push_raw(2, 8'hC5, 1'b0);
    push_raw(2, 8'h5A, 1'b0);
    push_raw(2, 8'h77, 1'b1);
    exp_q.push_back({3'd2, 8'hC5});
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    check("midreset_first_byte", 32'(t < 1000), 32'd1);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check("midreset_outputs", 32'({grant_out, uart_data_out, uart_send_out, busy_out, timeout_out}), 32'd0);
    clear_queues();
    model_ptr = NUM_REQ - 1;
    repeat (2) @(negedge clk_in);
    for (int r = NUM_REQ - 1; r >= 0; r--) add_packet(r, 1, {$urandom, $urandom});
    model_schedule();
    rst_in = 1'b0;
    wait_done("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : time_limit
    #500000;
    $display("FAIL time_limit: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit reached");
  end

endmodule
